// File: rtl/traffic_demand_pkg.sv
// Shared types and constants for the traffic demand detector front end.
package traffic_demand_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } demand_state_e;

  localparam int SYNC_DEPTH = 2;
  localparam int DB_CNT_W   = 4;

  // True when a run counter has reached its threshold on this sample.
  function automatic logic run_done(input logic [DB_CNT_W-1:0] cnt,
                                    input logic [DB_CNT_W-1:0] last);
    return (cnt >= last);
  endfunction

endpackage

// File: rtl/demand_channel.sv
// One direction of demand detection: 2-flop synchronizer, debounce, demand FSM
// and, when DEMAND_COUNT_EN is defined, a saturating arrival counter.
module demand_channel
  import traffic_demand_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RELEASE_CYCLES  = 2,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sensor,
  input  logic               green,
  output logic               detect
`ifdef DEMAND_COUNT_EN
  ,
  output logic [COUNT_W-1:0] arrivals
`endif
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 ||
      RELEASE_CYCLES < 1 || RELEASE_CYCLES > 15 || COUNT_W < 1) begin : g_param_check
    $error("demand_channel: parameter out of legal range");
  end

  // Thresholds expressed as "count already at N-1" so the counter never overflows.
  localparam logic [DB_CNT_W-1:0] DEB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_CNT_W-1:0] REL_LAST = DB_CNT_W'(RELEASE_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  sensed;
  logic [DB_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  presence_q, presence_d;
  demand_state_e         state_q, state_d;
  logic                  detect_q, detect_d;

  assign sensed = sync_q[SYNC_DEPTH-1];
  assign detect = detect_q;

  // Stage 0: synchronizer shift
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], sensor};
  end

  // Stage 1: debounce; the counter runs toward whichever level would flip presence
  always_comb begin
    cnt_d      = cnt_q;
    presence_d = presence_q;
    if (sensed != presence_q) begin
      if (run_done(cnt_q, presence_q ? REL_LAST : DEB_LAST)) begin
        presence_d = ~presence_q;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Stage 2: demand FSM, detect registered from the next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (presence_q && !green) state_d = PENDING;
      PENDING: if (green) state_d = SERVING;
      SERVING: if (!green) state_d = presence_q ? PENDING : IDLE;
      default: state_d = IDLE;
    endcase
    detect_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      presence_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      presence_q <= presence_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      detect_q <= detect_d;
    end
  end

`ifdef DEMAND_COUNT_EN
  logic [COUNT_W-1:0] arrivals_q, arrivals_d;

  assign arrivals = arrivals_q;

  // Counts every presence rise, independent of the FSM, and sticks at all-ones.
  always_comb begin
    arrivals_d = arrivals_q;
    if (presence_d && !presence_q && (arrivals_q != '1)) begin
      arrivals_d = arrivals_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arrivals_q <= '0;
    end else begin
      arrivals_q <= arrivals_d;
    end
  end
`endif

endmodule

// File: rtl/traffic_demand_detector.sv
// NS/EW vehicle demand front end for the traffic controller; two independent channels.
// Define DEMAND_COUNT_EN to add the ns_arrivals/ew_arrivals saturating counters.
module traffic_demand_detector
  import traffic_demand_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RELEASE_CYCLES  = 2,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               NS_SENSOR,
  input  logic               EW_SENSOR,
  input  logic               NS_GREEN,
  input  logic               EW_GREEN,
  output logic               NS_VEHICLE_DETECT,
  output logic               EW_VEHICLE_DETECT
`ifdef DEMAND_COUNT_EN
  ,
  output logic [COUNT_W-1:0] ns_arrivals,
  output logic [COUNT_W-1:0] ew_arrivals
`endif
);

  demand_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RELEASE_CYCLES  (RELEASE_CYCLES),
    .COUNT_W         (COUNT_W)
  ) u_ns (
    .clk      (clk),
    .rst      (rst),
    .sensor   (NS_SENSOR),
    .green    (NS_GREEN),
    .detect   (NS_VEHICLE_DETECT)
`ifdef DEMAND_COUNT_EN
    ,
    .arrivals (ns_arrivals)
`endif
  );

  demand_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RELEASE_CYCLES  (RELEASE_CYCLES),
    .COUNT_W         (COUNT_W)
  ) u_ew (
    .clk      (clk),
    .rst      (rst),
    .sensor   (EW_SENSOR),
    .green    (EW_GREEN),
    .detect   (EW_VEHICLE_DETECT)
`ifdef DEMAND_COUNT_EN
    ,
    .arrivals (ew_arrivals)
`endif
  );

endmodule
